// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo
//   Watches the CPU A0 register, logs every change as {value, timestamp} into a
//   first-word-fall-through FIFO, and exposes the head entry on a valid/ready
//   drain port. The timestamp is a free-running cycle counter.
//
// Ports
//   clk        in   1               CPU clock, rising edge
//   rst        in   1               asynchronous reset, active-low
//   en         in   1               capture enable
//   a0_i       in   WIDTH           A0 from CPU top
//   out_valid  out  1               head entry available
//   out_ready  in   1               consumer accepts head entry
//   out_data   out  WIDTH           head entry A0 value (0 while empty)
//   out_ts     out  TS_WIDTH        head entry timestamp (0 while empty)
//   count      out  $clog2(DEPTH)+1 occupancy, 0..DEPTH
//   overflow   out  1               sticky: a change was dropped while full
module a0_trace_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           a0_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0]    data_mem [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem   [DEPTH];

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count_q;
  logic [WIDTH-1:0]    prev_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic                overflow_q;

  logic push;
  logic pop;
  logic full;
  logic wr_ok;

  assign full  = (count_q == FULL_CNT);
  assign push  = en && (a0_i != prev_q);
  assign pop   = out_valid && out_ready;
  // When full, a push only lands if the head is leaving on the same edge.
  assign wr_ok = push && (!full || pop);

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_ts    = out_valid ? ts_mem[rd_ptr]   : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Storage is deliberately not reset; the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_mem[wr_ptr] <= a0_i;
      ts_mem[wr_ptr]   <= ts_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      prev_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      if (en) begin
        prev_q <= a0_i;
      end
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_ok && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !wr_ok) begin
        count_q <= count_q - CW'(1);
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_a0_trace_fifo.sv
module tb_a0_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] a0_i;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_ts;
  logic [3:0]  count;
  logic        overflow;

  logic        rst4;
  logic        en4;
  logic [31:0] a0_4;
  logic        out_ready4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [3:0]  out_ts4;
  logic [3:0]  count4;
  logic        overflow4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  a0_trace_fifo #(.WIDTH(32), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .a0_i(a0_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ts(out_ts),
    .count(count), .overflow(overflow)
  );

  a0_trace_fifo #(.WIDTH(32), .DEPTH(8), .TS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .a0_i(a0_4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4), .out_ts(out_ts4),
    .count(count4), .overflow(overflow4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; a0_i = '0; out_ready = 1'b0;
    rst4 = 1'b0; en4 = 1'b1; a0_4 = '0; out_ready4 = 1'b0;
    #12;
    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst = 1'b1;

    // 1: first change at cycle 3 -> {5, 3}
    tick(); tick(); tick();
    check("t1_no_entry_yet", 64'(count), 64'd0);
    a0_i = 32'd5;
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'd5);
    check("t1_ts", 64'(out_ts), 64'd3);
    check("t1_count", 64'(count), 64'd1);

    // drain it, then pop on empty must not underflow
    out_ready = 1'b1;
    tick();
    check("t1_drained", 64'(count), 64'd0);
    tick();
    check("empty_pop_count", 64'(count), 64'd0);
    check("empty_pop_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // 2: one change, then A0 held for 20 cycles
    a0_i = 32'd7;
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("t2_count", 64'(count), 64'd1);
    check("t2_data", 64'(out_data), 64'd7);
    out_ready = 1'b1;
    tick();
    check("t2_drained", 64'(count), 64'd0);
    out_ready = 1'b0;

    // 4: fill exactly, then push and pop on the same edge
    for (int i = 0; i < 8; i++) begin
      a0_i = 32'd200 + 32'(i);
      tick();
    end
    check("t4_full_count", 64'(count), 64'd8);
    check("t4_full_ovf", 64'(overflow), 64'd0);
    a0_i = 32'd208;
    out_ready = 1'b1;
    tick();
    check("t4_pp_count", 64'(count), 64'd8);
    check("t4_pp_ovf", 64'(overflow), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t4_drain%0d", i), 64'(out_data), 64'd200 + 64'(i));
      tick();
    end
    check("t4_empty", 64'(count), 64'd0);
    out_ready = 1'b0;

    // 3: nine changes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      a0_i = 32'd100 + 32'(i);
      tick();
    end
    check("t3_count", 64'(count), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_drain%0d", i), 64'(out_data), 64'd100 + 64'(i));
      tick();
    end
    check("t3_empty_count", 64'(count), 64'd0);
    check("t3_empty_data", 64'(out_data), 64'd0);
    check("t3_empty_ts", 64'(out_ts), 64'd0);
    check("t3_ovf_sticky", 64'(overflow), 64'd1);
    out_ready = 1'b0;

    // 5: en=0 while toggling, then re-enable on the last captured value (108)
    en = 1'b0;
    a0_i = 32'd1; tick();
    a0_i = 32'd2; tick();
    a0_i = 32'd3; tick();
    check("t5_en0_count", 64'(count), 64'd0);
    a0_i = 32'd108;
    en = 1'b1;
    tick();
    check("t5_same_count", 64'(count), 64'd0);
    a0_i = 32'd55;
    tick();
    check("t5_change_count", 64'(count), 64'd1);
    check("t5_change_data", 64'(out_data), 64'd55);

    // 6: 4-bit timestamp wrap, change at cycle 17 -> ts 1
    #3;
    rst4 = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    check("t6_before", 64'(count4), 64'd0);
    a0_4 = 32'd9;
    tick();
    check("t6_data", 64'(out_data4), 64'd9);
    check("t6_ts", 64'(out_ts4), 64'd1);
    a0_4 = 32'd10; tick();
    a0_4 = 32'd11; tick();
    check("t6_count3", 64'(count4), 64'd3);
    check("t6_ovf", 64'(overflow4), 64'd0);
    rst4 = 1'b0;
    #2;
    check("t6_async_valid", 64'(out_valid4), 64'd0);
    check("t6_async_count", 64'(count4), 64'd0);
    check("t6_async_data", 64'(out_data4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
